branch_resolve_pipe: RTL and testbench
======================================

Name: branch_resolve_pipe

Overview:
- Parametrised successor to the single-cycle B-type branch block.
- Resolves RV32/RV64 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in a 2-stage valid/ready pipeline with stall and flush.
- Computes taken, target, next PC and mispredict, and keeps saturating branch/taken statistics counters.
- Sits between decode/register-read and the PC-select logic of the processor core.

Parameters:
- XLEN, 32, operand/PC/immediate width (32 or 64).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  branch request valid.
- in_ready  output  1  block can accept request this cycle.
- funct3  input  3  branch condition code.
- rs1_val  input  XLEN  source operand 1.
- rs2_val  input  XLEN  source operand 2.
- pc  input  XLEN  PC of the branch instruction.
- imm  input  XLEN  sign-extended B-immediate, bit0 = 0.
- pred_taken  input  1  front-end prediction.
- flush  input  1  kill all in-flight requests.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_taken  output  1  branch taken.
- out_target  output  XLEN  pc + imm.
- out_next_pc  output  XLEN  taken ? target : pc + 4.
- out_mispredict  output  1  out_taken != pred_taken, or illegal.
- out_illegal  output  1  funct3 is 010 or 011.
- out_misaligned  output  1  taken and target[1:0] != 0.
- branch_count  output  CNT_W  number of retired results.
- taken_count  output  CNT_W  number of retired taken results.

Behaviour:
- Reset (reset=0, async): both stage valids cleared; all outputs 0; counters 0. Deasserting reset must not create a valid.
- Stage 1 (S1) registers funct3, operands, pc, imm, pred_taken on input handshake (in_valid && in_ready).
- Stage 2 (S2) registers the computed taken, target, next_pc and flags from S1 when S1 advances.
- Latency: an accepted request appears on out_valid exactly 2 cycles later when out_ready is held high.
- Throughput: 1 per cycle.
- Advance rules:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, purely combinational from state and out_ready; never depends on in_valid.
- Backpressure: with out_ready=0 the pipeline holds 2 entries, then in_ready=0. All out_* fields stay stable while out_valid=1 and out_ready=0.
- Conditions (funct3):
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010/011: illegal; out_taken=0, next_pc=pc+4, out_illegal=1, out_mispredict=1.
- Arithmetic: target = pc + imm and pc + 4 wrap modulo 2^XLEN; no overflow flag.
- out_misaligned is reported only for taken branches; the result still reports target and taken unchanged.
- Flush (sync): clears s1_valid and s2_valid at the next edge. Any request handshaking in the flush cycle is discarded. Counters are not incremented for a result that is flushed, even if out_ready=1 in that cycle. in_ready follows its normal equation during flush.
- Counters:
  - branch_count += 1 on each output handshake (out_valid && out_ready && !flush).
  - taken_count additionally += 1 if out_taken.
  - Both saturate at 2^CNT_W - 1 (no wrap).
- Reset mid-operation drops all in-flight entries immediately; counters return to 0.

Test Plan:
- Reset/idle: hold reset=0 with in_valid=1 → out_valid=0, in_ready=1 after release, counters 0, and no spurious output after release.
- Condition sweep (XLEN=32): rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20 for each funct3 → taken for BNE, BLT, BGEU; not taken for BEQ, BGE, BLTU. target=0x120; next_pc is 0x120 or 0x104 accordingly; result 2 cycles after accept.
- Illegal and mispredict: funct3=010, pred_taken=1 → out_taken=0, out_illegal=1, out_mispredict=1, next_pc=pc+4. BEQ equal operands with pred_taken=0 → mispredict=1.
- Wrap/misalign: pc=0xFFFFFFFC, imm=0x8, BEQ taken → target=0x00000004. imm=0x6 → target=0x00000002 and out_misaligned=1.
- Backpressure and stream: 5 back-to-back requests with out_ready=0 for 4 cycles → in_ready drops after 2 accepts and outputs stay stable. Releasing out_ready delivers all 5 in order, none lost or duplicated; branch_count=5.
- Flush and saturation (CNT_W=4):
  - Assert flush with 2 entries in flight → out_valid=0 next cycle and counters unchanged.
  - Retire 20 taken branches → branch_count=taken_count=15 (saturated).

Source files
------------

// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe
//   Two-stage valid/ready pipeline that resolves RV32/RV64 conditional
//   branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and produces taken, target,
//   next PC, mispredict, illegal and misaligned flags. It also keeps
//   saturating counters of retired and retired-taken branches.
//
//   S1 holds the raw request. S2 holds the resolved result, which drives
//   the out_* ports directly.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake
//   funct3, rs1_val, rs2_val, pc, imm, pred_taken : request payload
//   flush             : synchronous kill of both stages
//   out_valid/out_ready : result handshake
//   out_taken, out_target, out_next_pc, out_mispredict,
//   out_illegal, out_misaligned : result payload
//   branch_count, taken_count   : saturating retire statistics
module branch_resolve_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             out_misaligned,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    // Stage 1 state
    logic            s1_valid_q, s1_valid_d;
    logic [2:0]      s1_funct3_q, s1_funct3_d;
    logic [XLEN-1:0] s1_rs1_q, s1_rs1_d;
    logic [XLEN-1:0] s1_rs2_q, s1_rs2_d;
    logic [XLEN-1:0] s1_pc_q, s1_pc_d;
    logic [XLEN-1:0] s1_imm_q, s1_imm_d;
    logic            s1_pred_q, s1_pred_d;

    // Stage 2 state
    logic            s2_valid_q, s2_valid_d;
    logic            s2_taken_q, s2_taken_d;
    logic [XLEN-1:0] s2_target_q, s2_target_d;
    logic [XLEN-1:0] s2_next_pc_q, s2_next_pc_d;
    logic            s2_mispred_q, s2_mispred_d;
    logic            s2_illegal_q, s2_illegal_d;
    logic            s2_misal_q, s2_misal_d;

    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic s1_en, s2_en, accept, retire;

    // Resolution of the S1 entry
    logic            res_taken, res_illegal;
    logic [XLEN-1:0] res_target;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;
    assign accept   = in_valid && s1_en;
    // A result presented during flush is killed, so it never retires.
    assign retire   = s2_valid_q && out_ready && !flush;

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        res_target  = s1_pc_q + s1_imm_q;
        case (s1_funct3_q)
            3'b000:  res_taken = (s1_rs1_q == s1_rs2_q);
            3'b001:  res_taken = (s1_rs1_q != s1_rs2_q);
            3'b100:  res_taken = ($signed(s1_rs1_q) <  $signed(s1_rs2_q));
            3'b101:  res_taken = ($signed(s1_rs1_q) >= $signed(s1_rs2_q));
            3'b110:  res_taken = (s1_rs1_q <  s1_rs2_q);
            3'b111:  res_taken = (s1_rs1_q >= s1_rs2_q);
            default: res_illegal = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_en ? in_valid : s1_valid_q;
        s1_funct3_d = s1_funct3_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_pc_d     = s1_pc_q;
        s1_imm_d    = s1_imm_q;
        s1_pred_d   = s1_pred_q;
        if (accept) begin
            s1_funct3_d = funct3;
            s1_rs1_d    = rs1_val;
            s1_rs2_d    = rs2_val;
            s1_pc_d     = pc;
            s1_imm_d    = imm;
            s1_pred_d   = pred_taken;
        end

        s2_valid_d   = s2_en ? s1_valid_q : s2_valid_q;
        s2_taken_d   = s2_taken_q;
        s2_target_d  = s2_target_q;
        s2_next_pc_d = s2_next_pc_q;
        s2_mispred_d = s2_mispred_q;
        s2_illegal_d = s2_illegal_q;
        s2_misal_d   = s2_misal_q;
        // Payload only moves with a real entry, so held outputs stay stable.
        if (s2_en && s1_valid_q) begin
            s2_taken_d   = res_taken;
            s2_target_d  = res_target;
            s2_next_pc_d = res_taken ? res_target : s1_pc_q + XLEN'(4);
            s2_mispred_d = (res_taken != s1_pred_q) || res_illegal;
            s2_illegal_d = res_illegal;
            s2_misal_d   = res_taken && (res_target[1:0] != 2'b00);
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        if (retire) begin
            if (branch_count_q != {CNT_W{1'b1}})
                branch_count_d = branch_count_q + CNT_W'(1);
            if (s2_taken_q && taken_count_q != {CNT_W{1'b1}})
                taken_count_d = taken_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q     <= 1'b0;
            s1_funct3_q    <= '0;
            s1_rs1_q       <= '0;
            s1_rs2_q       <= '0;
            s1_pc_q        <= '0;
            s1_imm_q       <= '0;
            s1_pred_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_taken_q     <= 1'b0;
            s2_target_q    <= '0;
            s2_next_pc_q   <= '0;
            s2_mispred_q   <= 1'b0;
            s2_illegal_q   <= 1'b0;
            s2_misal_q     <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_funct3_q    <= s1_funct3_d;
            s1_rs1_q       <= s1_rs1_d;
            s1_rs2_q       <= s1_rs2_d;
            s1_pc_q        <= s1_pc_d;
            s1_imm_q       <= s1_imm_d;
            s1_pred_q      <= s1_pred_d;
            s2_valid_q     <= s2_valid_d;
            s2_taken_q     <= s2_taken_d;
            s2_target_q    <= s2_target_d;
            s2_next_pc_q   <= s2_next_pc_d;
            s2_mispred_q   <= s2_mispred_d;
            s2_illegal_q   <= s2_illegal_d;
            s2_misal_q     <= s2_misal_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_taken      = s2_taken_q;
    assign out_target     = s2_target_q;
    assign out_next_pc    = s2_next_pc_q;
    assign out_mispredict = s2_mispred_q;
    assign out_illegal    = s2_illegal_q;
    assign out_misaligned = s2_misal_q;
    assign branch_count   = branch_count_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Self-checking bench for branch_resolve_pipe (XLEN=32, CNT_W=4).
module tb_branch_resolve_pipe;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        mispred;
        logic        illegal;
        logic        misal;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0;
    logic        pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [31:0] out_target, out_next_pc;
    logic        out_mispredict, out_illegal, out_misaligned;
    logic [3:0]  branch_count, taken_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    res_t exp_q[$];
    res_t got_q[$];
    int   acc_cyc_q[$];
    int   ret_cyc_q[$];

    branch_resolve_pipe #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .out_misaligned(out_misaligned),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour of a single branch request.
    function automatic res_t model(input logic [2:0] f3, input logic [31:0] a, b, p, im,
                                   input logic pr);
        res_t r;
        logic t;
        logic ill;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = !($signed(a) < $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = !(a < b);
            default: t = 1'b0;
        endcase
        r.taken   = t;
        r.target  = p + im;
        r.next_pc = t ? p + im : p + 32'd4;
        r.mispred = (t != pr) || ill;
        r.illegal = ill;
        r.misal   = t && ((p + im) & 32'h3) != 0;
        return r;
    endfunction

    // One clock cycle: drive at negedge, record handshakes just before posedge.
    task automatic step(input logic v, input logic [2:0] f3, input logic [31:0] a, b, p, im,
                        input logic pr, input logic ordy, input logic fl, output logic acc);
        in_valid = v; funct3 = f3; rs1_val = a; rs2_val = b; pc = p; imm = im;
        pred_taken = pr; out_ready = ordy; flush = fl;
        #1;
        acc = v && in_ready && !fl;
        if (acc) begin
            exp_q.push_back(model(f3, a, b, p, im, pr));
            acc_cyc_q.push_back(cyc);
        end
        if (out_valid && ordy && !fl) begin
            got_q.push_back({out_taken, out_target, out_next_pc,
                             out_mispredict, out_illegal, out_misaligned});
            ret_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 3'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); ret_cyc_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; funct3 = 3'b001; rs1_val = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || branch_count !== 4'd0 || taken_count !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_hold: out_valid=%b bc=%0d tc=%0d exp 0/0/0",
                         out_valid, branch_count, taken_count);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b exp 1", in_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_spurious: out_valid=%b exp 0", out_valid);
            end
        end
    endtask

    task automatic test_conditions();
        logic [2:0] f3s[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic       exp_taken[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic a;
        res_t e, g;
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, f3s[i], 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, a);
        idle(4);
        vectors++;
        if (got_q.size() != 6) begin
            miscompares++;
            $display("FAIL cond_count: got %0d results exp 6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                vectors += 3;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL cond_f3_%0d: got %h exp %h", f3s[i], g, e);
                end
                if (g.taken !== exp_taken[i] || g.target !== 32'h120 ||
                    g.next_pc !== (exp_taken[i] ? 32'h120 : 32'h104)) begin
                    miscompares++;
                    $display("FAIL cond_table_%0d: taken=%b tgt=%h npc=%h exp taken=%b",
                             f3s[i], g.taken, g.target, g.next_pc, exp_taken[i]);
                end
                if (ret_cyc_q[i] - acc_cyc_q[i] != 2) begin
                    miscompares++;
                    $display("FAIL cond_latency_%0d: got %0d exp 2", f3s[i],
                             ret_cyc_q[i] - acc_cyc_q[i]);
                end
            end
        end
        vectors++;
        if (branch_count !== 4'd6 || taken_count !== 4'd3) begin
            miscompares++;
            $display("FAIL cond_counters: bc=%0d tc=%0d exp 6/3", branch_count, taken_count);
        end
    endtask

    task automatic test_illegal_mispredict();
        logic a;
        res_t e, g;
        do_reset();
        step(1'b1, 3'b010, 32'h5, 32'h5, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0, a);
        step(1'b1, 3'b011, 32'h5, 32'h6, 32'h300, 32'h40, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 3'b000, 32'h7, 32'h7, 32'h400, 32'h10, 1'b0, 1'b1, 1'b0, a);
        idle(4);
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL illegal_count: got %0d results exp 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL illegal_vec_%0d: got %h exp %h", i, g, e);
                end
                if (i == 0) begin
                    vectors++;
                    if (g.taken !== 1'b0 || g.illegal !== 1'b1 || g.mispred !== 1'b1 ||
                        g.next_pc !== 32'h204) begin
                        miscompares++;
                        $display("FAIL illegal_flags: t=%b ill=%b mp=%b npc=%h exp 0/1/1/204",
                                 g.taken, g.illegal, g.mispred, g.next_pc);
                    end
                end
                if (i == 2) begin
                    vectors++;
                    if (g.taken !== 1'b1 || g.mispred !== 1'b1 || g.illegal !== 1'b0) begin
                        miscompares++;
                        $display("FAIL beq_mispredict: t=%b mp=%b ill=%b exp 1/1/0",
                                 g.taken, g.mispred, g.illegal);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap_misalign();
        logic a;
        res_t e, g;
        do_reset();
        step(1'b1, 3'b000, 32'h9, 32'h9, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1, 1'b0, a);
        step(1'b1, 3'b000, 32'h9, 32'h9, 32'hFFFF_FFFC, 32'h6, 1'b1, 1'b1, 1'b0, a);
        idle(4);
        vectors++;
        if (got_q.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d results exp 2", got_q.size());
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors += 2;
            if (g !== e) begin
                miscompares++;
                $display("FAIL wrap_vec: got %h exp %h", g, e);
            end
            if (g.target !== 32'h4 || g.next_pc !== 32'h4 || g.misal !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_target: tgt=%h npc=%h mis=%b exp 4/4/0",
                         g.target, g.next_pc, g.misal);
            end
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors += 2;
            if (g !== e) begin
                miscompares++;
                $display("FAIL misalign_vec: got %h exp %h", g, e);
            end
            if (g.target !== 32'h2 || g.misal !== 1'b1 || g.taken !== 1'b1) begin
                miscompares++;
                $display("FAIL misalign_flag: tgt=%h mis=%b t=%b exp 2/1/1",
                         g.target, g.misal, g.taken);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs1s[5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        logic a;
        int   k = 0;
        int   guard = 0;
        res_t snap, now;
        res_t e, g;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 3'b001, rs1s[k], 32'h3, 32'h1000 + 32'(k * 16), 32'h40, 1'b1,
                 1'b0, 1'b0, a);
            if (a) k++;
            if (c == 2) snap = {out_taken, out_target, out_next_pc,
                                out_mispredict, out_illegal, out_misaligned};
        end
        #1;
        now = {out_taken, out_target, out_next_pc, out_mispredict, out_illegal, out_misaligned};
        vectors += 3;
        if (k != 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d exp 2", k);
        end
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready: in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid);
        end
        if (now !== snap) begin
            miscompares++;
            $display("FAIL bp_stable: got %h exp %h", now, snap);
        end
        while (got_q.size() < 5 && guard < 50) begin
            step(k < 5, 3'b001, rs1s[k < 5 ? k : 0], 32'h3, 32'h1000 + 32'(k * 16), 32'h40,
                 1'b1, 1'b1, 1'b0, a);
            if (a) k++;
            guard++;
        end
        idle(3);
        vectors += 2;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            miscompares++;
            $display("FAIL bp_stream_count: got %0d exp 5 (accepted %0d)",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL bp_order_%0d: got %h exp %h", i, g, e);
                end
            end
        end
        if (branch_count !== 4'd5) begin
            miscompares++;
            $display("FAIL bp_branch_count: got %0d exp 5", branch_count);
        end
    endtask

    task automatic test_flush();
        logic a;
        do_reset();
        step(1'b1, 3'b001, 32'h1, 32'h2, 32'h80, 32'h8, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 3'b001, 32'h1, 32'h2, 32'h90, 32'h8, 1'b1, 1'b0, 1'b0, a);
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre_valid: got %b exp 1", out_valid);
        end
        step(1'b1, 3'b001, 32'h1, 32'h2, 32'hA0, 32'h8, 1'b1, 1'b1, 1'b1, a);
        exp_q.delete(); acc_cyc_q.delete();
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid: got %b exp 0", out_valid);
        end
        if (branch_count !== 4'd0 || taken_count !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_counters: bc=%0d tc=%0d exp 0/0", branch_count, taken_count);
        end
        idle(3);
        vectors++;
        if (got_q.size() != 0 || branch_count !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_leak: results=%0d bc=%0d exp 0/0", got_q.size(), branch_count);
        end
    endtask

    task automatic test_saturation();
        logic a;
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b1, 3'b001, 32'(i + 10), 32'h1, 32'h500, 32'h10, 1'b1, 1'b1, 1'b0, a);
        idle(4);
        vectors += 2;
        if (got_q.size() != 20) begin
            miscompares++;
            $display("FAIL sat_results: got %0d exp 20", got_q.size());
        end
        if (branch_count !== 4'd15 || taken_count !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_counters: bc=%0d tc=%0d exp 15/15", branch_count, taken_count);
        end
        // Asynchronous reset mid-cycle with entries in flight.
        step(1'b1, 3'b001, 32'h1, 32'h2, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 3'b001, 32'h1, 32'h2, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, a);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || branch_count !== 4'd0 || taken_count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: out_valid=%b bc=%0d tc=%0d exp 0/0/0",
                     out_valid, branch_count, taken_count);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_conditions();
        test_illegal_mispredict();
        test_wrap_misalign();
        test_back_to_back();
        test_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
